// File: rtl/fetch_pkg.sv
// Shared fetch-sequencer definitions: state encoding, PC-mux selects and helpers.
// The instruction unit and main control import the same select constants.
package fetch_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LOAD  = 3'd2,
    ST_ISSUE = 3'd3,
    ST_REDIR = 3'd4
  } fetch_state_t;

  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_JUMP   = 2'b01;
  localparam logic [1:0] SEL_BRANCH = 2'b10;

  localparam int CNT_W  = 16;
  localparam int WAIT_W = 2;

  // The unused encoding 11 falls back to the register target (PC_in).
  function automatic logic [1:0] norm_sel(input logic [1:0] sel);
    return (sel == 2'b11) ? SEL_PC4 : sel;
  endfunction

endpackage

// File: rtl/fetch_wait_cnt.sv
// Loadable 2-bit down-counter with zero flag; times the instruction-memory read latency.
module fetch_wait_cnt
  import fetch_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_reset_n,
  input  logic              i_load,
  input  logic [WAIT_W-1:0] i_load_val,
  input  logic              i_dec,
  output logic              o_zero
);

  logic [WAIT_W-1:0] r_cnt;

  // Saturates at zero so a lingering decrement cannot wrap to 3.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WAIT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fetch_sequencer.sv
// Moore FSM sequencing PC / instruction memory / IR for the multicycle MIPS core.
// Issue handshake: ir_valid stays high until issue_rdy; transfer on ir_valid & issue_rdy in the same cycle.
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int IM_LAT = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             halt,
  input  logic             issue_rdy,
  input  logic             redir_req,
  input  logic [1:0]       redir_sel,
  output logic             pc_ld,
  output logic             pc_inc,
  output logic             ir_ld,
  output logic             im_cs,
  output logic             im_rd,
  output logic             im_wr,
  output logic [1:0]       pc_sel,
  output logic             ir_valid,
  output logic             busy,
  output logic [CNT_W-1:0] fetch_cnt,
  output fetch_state_t     dbg_state
);

  localparam logic [WAIT_W-1:0] LAT_M1 = WAIT_W'(IM_LAT - 1);

  fetch_state_t     r_state;
  fetch_state_t     w_next;
  logic [1:0]       r_sel;
  logic [CNT_W-1:0] r_fetch_cnt;
  logic             w_go;
  logic             w_hs;
  logic             w_wait_zero;
  logic             w_wait_load;
  logic             w_wait_dec;

  assign w_go = run & ~halt;
  assign w_hs = (r_state == ST_ISSUE) & issue_rdy;

  // Reload on every entry into FETCH so a fresh fetch always waits the full latency.
  assign w_wait_load = (w_next == ST_FETCH) && (r_state != ST_FETCH);
  assign w_wait_dec  = (r_state == ST_FETCH);

  fetch_wait_cnt u_wait_cnt (
    .i_clk      (clk),
    .i_reset_n  (reset),
    .i_load     (w_wait_load),
    .i_load_val (LAT_M1),
    .i_dec      (w_wait_dec),
    .o_zero     (w_wait_zero)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_go) w_next = ST_FETCH;
      ST_FETCH: if (w_wait_zero) w_next = ST_LOAD;
      ST_LOAD:  w_next = ST_ISSUE;
      ST_ISSUE: begin
        if (issue_rdy) begin
          if (redir_req) w_next = ST_REDIR;
          else if (w_go) w_next = ST_FETCH;
          else           w_next = ST_IDLE;
        end
      end
      ST_REDIR: w_next = w_go ? ST_FETCH : ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Redirect source is captured only on the accepting handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sel <= SEL_PC4;
    end else if (w_hs && redir_req) begin
      r_sel <= norm_sel(redir_sel);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch_cnt <= '0;
    end else if (w_hs) begin
      r_fetch_cnt <= r_fetch_cnt + CNT_W'(1);
    end
  end

  always_comb begin
    pc_ld    = 1'b0;
    pc_inc   = 1'b0;
    ir_ld    = 1'b0;
    im_cs    = 1'b0;
    im_rd    = 1'b0;
    im_wr    = 1'b0;
    pc_sel   = SEL_PC4;
    ir_valid = 1'b0;
    busy     = (r_state != ST_IDLE);
    case (r_state)
      ST_FETCH: begin
        im_cs = 1'b1;
        im_rd = 1'b1;
      end
      // IR captures the word for the old PC while the PC steps to PC+4.
      ST_LOAD: begin
        im_cs  = 1'b1;
        im_rd  = 1'b1;
        ir_ld  = 1'b1;
        pc_inc = 1'b1;
      end
      ST_ISSUE: ir_valid = 1'b1;
      ST_REDIR: begin
        pc_ld  = 1'b1;
        pc_sel = r_sel;
      end
      default: ;
    endcase
  end

  assign fetch_cnt = r_fetch_cnt;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: phase-level reference model feeding a cycle scoreboard,
// plus directed latency, wrap and asynchronous-reset checks.
module tb_fetch_sequencer;
  import fetch_pkg::*;

  localparam int LAT  = 1;
  localparam int LAT4 = 4;
  localparam int W    = 26;

  typedef enum int {P_IDLE, P_FETCH, P_LOAD, P_ISSUE, P_REDIR} phase_e;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, run, halt, issue_rdy, redir_req;
  logic [1:0] redir_sel;
  logic pc_ld, pc_inc, ir_ld, im_cs, im_rd, im_wr, ir_valid, busy;
  logic [1:0] pc_sel;
  logic [15:0] fetch_cnt;
  fetch_state_t dbg_state;

  logic reset4, run4, halt4, rdy4, req4;
  logic [1:0] sel4;
  logic pc_ld4, pc_inc4, ir_ld4, im_cs4, im_rd4, im_wr4, ir_valid4, busy4;
  logic [1:0] pc_sel4;
  logic [15:0] fetch_cnt4;
  fetch_state_t dbg_state4;

  fetch_sequencer #(.IM_LAT(LAT)) dut (
    .clk(clk), .reset(reset), .run(run), .halt(halt), .issue_rdy(issue_rdy),
    .redir_req(redir_req), .redir_sel(redir_sel), .pc_ld(pc_ld), .pc_inc(pc_inc),
    .ir_ld(ir_ld), .im_cs(im_cs), .im_rd(im_rd), .im_wr(im_wr), .pc_sel(pc_sel),
    .ir_valid(ir_valid), .busy(busy), .fetch_cnt(fetch_cnt), .dbg_state(dbg_state)
  );

  fetch_sequencer #(.IM_LAT(LAT4)) dut4 (
    .clk(clk), .reset(reset4), .run(run4), .halt(halt4), .issue_rdy(rdy4),
    .redir_req(req4), .redir_sel(sel4), .pc_ld(pc_ld4), .pc_inc(pc_inc4),
    .ir_ld(ir_ld4), .im_cs(im_cs4), .im_rd(im_rd4), .im_wr(im_wr4), .pc_sel(pc_sel4),
    .ir_valid(ir_valid4), .busy(busy4), .fetch_cnt(fetch_cnt4), .dbg_state(dbg_state4)
  );

  // scoreboard
  logic [W-1:0] exp_q[$];
  logic [15:0]  m_cnt;
  bit           mon_en = 1'b0;
  int           n_cmp  = 0;
  int           n_err  = 0;

  function automatic logic [W-1:0] cur_vec();
    return {pc_ld, pc_inc, ir_ld, im_cs, im_rd, im_wr, pc_sel, ir_valid, busy, fetch_cnt};
  endfunction

  // Expected outputs of one cycle, straight from the per-phase strobe table.
  function automatic logic [W-1:0] ev(input phase_e p, input logic [1:0] sel, input logic [15:0] cnt);
    logic pl, pi, il, cs, rv, bz;
    logic [1:0] ps;
    pl = (p == P_REDIR);
    pi = (p == P_LOAD);
    il = (p == P_LOAD);
    cs = (p == P_FETCH) || (p == P_LOAD);
    rv = (p == P_ISSUE);
    bz = (p != P_IDLE);
    ps = pl ? sel : 2'b00;
    return {pl, pi, il, cs, cs, 1'b0, ps, rv, bz, cnt};
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      logic [W-1:0] e;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL scoreboard_underflow: got %h expected nothing queued", cur_vec());
      end else begin
        e = exp_q.pop_front();
        if (cur_vec() !== e) begin
          n_err++;
          $display("FAIL scoreboard_cycle @%0t: got %h expected %h", $time, cur_vec(), e);
        end
      end
    end
  end

  // driver tasks
  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] rs();
    return 2'($urandom_range(0, 3));
  endfunction

  task automatic pick_go(input bit go, output logic r, output logic h);
    if (go) begin
      r = 1'b1; h = 1'b0;
    end else begin
      case ($urandom_range(0, 2))
        0:       begin r = 1'b0; h = 1'b0; end
        1:       begin r = 1'b0; h = 1'b1; end
        default: begin r = 1'b1; h = 1'b1; end
      endcase
    end
  endtask

  task automatic step(input phase_e p, input logic [1:0] esel, input logic r, input logic h,
                      input logic rdy, input logic req, input logic [1:0] s);
    exp_q.push_back(ev(p, esel, m_cnt));
    run = r; halt = h; issue_rdy = rdy; redir_req = req; redir_sel = s;
    @(posedge clk); #1;
  endtask

  // One instruction, entered in its first FETCH cycle.
  task automatic do_instr(input int w, input bit rd, input logic [1:0] s, input bit stop, input bit restart);
    logic r, h;
    int n;
    for (int i = 0; i < LAT; i++) step(P_FETCH, 2'b00, rb(), rb(), rb(), rb(), rs());
    step(P_LOAD, 2'b00, rb(), rb(), rb(), rb(), rs());
    for (int i = 0; i < w; i++) step(P_ISSUE, 2'b00, rb(), rb(), 1'b0, rb(), rs());
    if (rd) begin
      step(P_ISSUE, 2'b00, rb(), rb(), 1'b1, 1'b1, s);
      m_cnt++;
      pick_go(!stop, r, h);
      step(P_REDIR, (s == 2'b11) ? 2'b00 : s, r, h, rb(), rb(), rs());
    end else begin
      pick_go(!stop, r, h);
      step(P_ISSUE, 2'b00, r, h, 1'b1, 1'b0, rs());
      m_cnt++;
    end
    if (stop) begin
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) begin
        pick_go(1'b0, r, h);
        step(P_IDLE, 2'b00, r, h, rb(), rb(), rs());
      end
      if (restart) step(P_IDLE, 2'b00, 1'b1, 1'b0, rb(), rb(), rs());
    end
  endtask

  task automatic lat4_window(input string tag);
    int prev_rise, runlen, nrise;
    logic prev_iv, prev_rd;
    prev_rise = -1; runlen = 0; nrise = 0; prev_iv = 1'b0; prev_rd = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      if (ir_valid4 && !prev_iv) begin
        if (prev_rise < 0) chk({tag, "_first_ir_valid"}, k, LAT4 + 1);
        else               chk({tag, "_period"}, k - prev_rise, LAT4 + 2);
        prev_rise = k;
        nrise++;
      end
      if (im_rd4) runlen++;
      else if (prev_rd) begin
        chk({tag, "_im_rd_run"}, runlen, LAT4 + 1);
        runlen = 0;
      end
      prev_iv = ir_valid4;
      prev_rd = im_rd4;
    end
    chk({tag, "_issue_count"}, nrise, 3);
  endtask

  initial begin
    bit rd, stop;
    int w;
    logic [1:0] s;

    reset = 1'b0; run = 1'b1; halt = 1'b0; issue_rdy = 1'b1; redir_req = 1'b0; redir_sel = 2'b00;
    reset4 = 1'b0; run4 = 1'b1; halt4 = 1'b0; rdy4 = 1'b1; req4 = 1'b0; sel4 = 2'b00;
    m_cnt = 16'h0;
    #23;
    chk("reset_outputs", 32'(cur_vec()), 32'h0);
    chk("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    run = 1'b0;
    #4 reset = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    step(P_IDLE, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    step(P_IDLE, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00);
    step(P_IDLE, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);

    // steady fetch, 3 cycles per instruction
    for (int i = 0; i < 4; i++) do_instr(0, 1'b0, 2'b00, 1'b0, 1'b0);
    chk("steady_cnt_after_12", 32'(fetch_cnt), 32'd4);

    do_instr(5, 1'b0, 2'b00, 1'b0, 1'b0);
    do_instr(0, 1'b1, 2'b01, 1'b0, 1'b0);
    do_instr(0, 1'b1, 2'b10, 1'b0, 1'b0);
    do_instr(0, 1'b1, 2'b11, 1'b0, 1'b0);
    do_instr(1, 1'b0, 2'b00, 1'b1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      w    = $urandom_range(0, 3);
      rd   = ($urandom_range(0, 2) == 0);
      s    = rs();
      stop = ($urandom_range(0, 4) == 0);
      do_instr(w, rd, s, stop, 1'b1);
    end
    do_instr(0, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("halted_idle_busy", 32'(busy), 32'd0);

    // counter wrap
    mon_en = 1'b0;
    force dut.r_fetch_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.r_fetch_cnt;
    m_cnt = 16'hFFFF;
    chk("wrap_preload", 32'(fetch_cnt), 32'hFFFF);
    mon_en = 1'b1;
    step(P_IDLE, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    do_instr(2, 1'b0, 2'b00, 1'b1, 1'b0);
    chk("wrap_to_zero", 32'(fetch_cnt), 32'h0);

    // asynchronous reset in the middle of REDIR
    step(P_IDLE, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    for (int i = 0; i < LAT; i++) step(P_FETCH, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    step(P_LOAD, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
    step(P_ISSUE, 2'b00, 1'b1, 1'b0, 1'b1, 1'b1, 2'b10);
    m_cnt++;
    mon_en = 1'b0;
    chk("pre_reset_redir_pc_ld", 32'(pc_ld), 32'd1);
    chk("pre_reset_redir_pc_sel", 32'(pc_sel), 32'd2);
    #2 reset = 1'b0;
    #1;
    chk("async_reset_redir_outputs", 32'(cur_vec()), 32'h0);
    chk("async_reset_redir_state", 32'(dbg_state), 32'(ST_IDLE));
    run = 1'b0;
    #3 reset = 1'b1;
    @(posedge clk); #1;
    m_cnt = 16'h0;
    mon_en = 1'b1;
    step(P_IDLE, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01);
    step(P_IDLE, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00);
    do_instr(0, 1'b0, 2'b00, 1'b1, 1'b0);
    mon_en = 1'b0;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    // IM_LAT = 4 instance: latency, period, mid-FETCH reset and restart
    @(posedge clk); #6;
    reset4 = 1'b1;
    lat4_window("lat4");
    chk("lat4_mid_fetch_im_rd", 32'(im_rd4), 32'd1);
    chk("lat4_cnt_before_reset", 32'(fetch_cnt4), 32'd3);
    #2 reset4 = 1'b0;
    #1;
    chk("lat4_async_reset_im", 32'({im_cs4, im_rd4, busy4}), 32'd0);
    chk("lat4_async_reset_cnt", 32'(fetch_cnt4), 32'd0);
    #3 reset4 = 1'b1;
    lat4_window("lat4_restart");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Moore control FSM that sequences the instruction fetch datapath (PC, instruction memory, IR, PC mux) for the multicycle MIPS core. It drives PC/IR load and increment strobes, instruction-memory chip-select/read, and the PC-mux select. It presents each fetched instruction to decode/execute through a valid/ready handshake, and applies jump, branch and register-target redirects reported back by execute. It sits between the instruction unit and the main control unit.

## Interface
- `IM_LAT`, default 1: instruction-memory read latency in cycles, from `im_cs`/`im_rd` assertion to valid memory output. Legal range 1–4.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: **asynchronous, active-low** reset.
- `run` in 1: fetch enable; level-sensitive.
- `halt` in 1: stop request; the FSM stops at the next instruction boundary.
- `issue_rdy` in 1: decode/execute accepts the presented instruction.
- `redir_req` in 1: redirect PC; sampled only in the issue-handshake cycle.
- `redir_sel` in 2: redirect source. 00 selects `PC_in` (register target, jr), 01 selects jump, 10 selects branch, 11 is treated as 00. Sampled with `redir_req`.
- `pc_ld`, `pc_inc`, `ir_ld` out 1: PC load, PC increment, IR load.
- `im_cs`, `im_rd` out 1: instruction-memory chip select and read.
- `im_wr` out 1: constant 0.
- `pc_sel` out 2: PC mux select.
- `ir_valid` out 1: IR holds an un-accepted instruction.
- `busy` out 1: FSM is not in IDLE.
- `fetch_cnt` out 16: count of accepted issues.

## Operation
- States are IDLE, FETCH, LOAD, ISSUE, REDIR. All outputs are decoded from the registered state, plus the latched redirect select.
- **IDLE**: all strobes 0. Moves to FETCH when `run & ~halt`.
- **FETCH**:
  - Drives `im_cs=im_rd=1`.
  - Loads the wait counter with `IM_LAT-1` on entry and decrements it each cycle.
  - Moves to LOAD when the counter reads 0 (IM_LAT cycles in FETCH).
- **LOAD**: exactly one cycle.
  - Drives `im_cs=im_rd=1`, `ir_ld=1`, `pc_inc=1`.
  - The IR captures the memory word for the old PC, and the PC advances to PC+4 on the same edge.
  - Moves to ISSUE.
- **ISSUE**: `ir_valid=1`; holds until `issue_rdy`. On the handshake (`ir_valid & issue_rdy`):
  - `fetch_cnt` increments; it wraps 0xFFFF → 0x0000.
  - If `redir_req=1`, latch `redir_sel` (11 stored as 00) and go to REDIR.
  - Else if `run & ~halt`, go to FETCH.
  - Else go to IDLE.
- **REDIR**: one cycle.
  - Drives `pc_ld=1` and `pc_sel` = latched select.
  - The IR still holds the redirecting instruction, so jump and branch targets use the current IR and PC+4.
  - Then goes to FETCH if `run & ~halt`, else IDLE.
- `pc_sel`=00 in every state except REDIR.
- `pc_ld` and `pc_inc` are never asserted together.
- **halt/run**: `halt` high or `run` low never aborts FETCH/LOAD/ISSUE/REDIR. It only changes the boundary decisions above. An instruction already in ISSUE is still presented until accepted.
- `redir_req` is ignored outside the handshake cycle.

## Timing
- Reset state:
  - State IDLE.
  - All outputs 0, including `fetch_cnt`=0 and `pc_sel`=00.
  - Latched select = 00.
- The asynchronous assertion of `reset` forces outputs to these values immediately, including mid-FETCH or mid-REDIR. No partial fetch is resumed after release.
- Fetch latency: `run` sampled high in IDLE at edge 0 gives FETCH for cycles 1..IM_LAT, LOAD in cycle IM_LAT+1, and `ir_valid` from cycle IM_LAT+2.
- Throughput with `issue_rdy` held high:
  - IM_LAT+2 cycles per instruction with no redirect.
  - IM_LAT+3 cycles per instruction with a redirect.
- `fetch_cnt` updates on the handshake edge and is visible the following cycle.

## Structure
- Shared package `fetch_pkg`:
  - State encoding: IDLE=0, FETCH=1, LOAD=2, ISSUE=3, REDIR=4; 3 bits.
  - PC-select constants: SEL_PC4=2'b00, SEL_JUMP=2'b01, SEL_BRANCH=2'b10. The instruction unit and the main control share these.
- One sub-module, `fetch_wait_cnt`: a 2-bit loadable down-counter with a zero flag, used for the IM_LAT wait.
- Everything else is a single FSM process plus an output decode.

## Test plan
- **Reset, then steady fetch**: reset low → all outputs 0. Release with `run=1`, `issue_rdy=1`, IM_LAT=1 → strobe pattern FETCH, LOAD (`ir_ld`=`pc_inc`=1), ISSUE repeating every 3 cycles; `fetch_cnt` reaches 4 after 12 cycles.
- **Backpressure**: `issue_rdy=0` for 5 cycles in ISSUE → `ir_valid` held 5 cycles, no `pc_inc`/`ir_ld`, `fetch_cnt` unchanged. Assert `issue_rdy` → count +1 and FETCH next.
- **Redirects**: `redir_req=1` with `redir_sel`=01, then 10, then 11 at handshake → a one-cycle REDIR with `pc_ld=1` and `pc_sel`=01, 10, 00 respectively, then FETCH.
- **Halt**: `halt=1` during FETCH → LOAD and ISSUE still complete. After acceptance the FSM goes to IDLE, `busy=0`, and it stays in IDLE while `halt=1` even with `run=1`.
- **Latency parameter**: IM_LAT=4 → `im_rd` high for 5 consecutive cycles per fetch, and the instruction period is 6 cycles.
- **Async reset / counter wrap**:
  - Assert `reset` mid-FETCH and mid-REDIR → outputs drop before the next clock edge, and fetch restarts from IDLE.
  - Preload `fetch_cnt` to 0xFFFF via force, then one handshake → 0x0000.
